rtn_addr_stack: RTL and testbench
=================================

RTN_ADDR_STACK -- requirements
Module: rtn_addr_stack

Interface
REQ-001 Parameter ADDR_W, default 8, width of a stored return address (equals PC width).
REQ-002 Parameter DEPTH, default 8, number of stack entries (power of two, at least 2).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port Push, input, 1, call taken this cycle; store Push_Addr.
REQ-006 Port Pop, input, 1, return taken this cycle; discard the top entry.
REQ-007 Port Push_Addr, input, ADDR_W, return address to save (PC+1 of the call instruction).
REQ-008 Port Err_Clr, input, 1, synchronous clear of the sticky error flags.
REQ-009 Port Return_Addr, output, ADDR_W, registered top-of-stack value, consumed by the program counter on return.
REQ-010 Port Stack_Cnt, output, $clog2(DEPTH)+1, registered number of valid entries.
REQ-011 Port Stack_Full, output, 1, high when Stack_Cnt equals DEPTH.
REQ-012 Port Stack_Empty, output, 1, high when Stack_Cnt equals 0.
REQ-013 Port Stack_Ovfl, output, 1, sticky flag: a push was dropped.
REQ-014 Port Stack_Unfl, output, 1, sticky flag: a pop was attempted while the stack was empty.

Function
REQ-015 The block SHALL implement a LIFO of DEPTH entries, each ADDR_W wide, using a registered pointer and count.
REQ-016 Push only, not full: the block SHALL write Push_Addr to the next entry and increment Stack_Cnt; Return_Addr SHALL equal Push_Addr in the following cycle.
REQ-017 Pop only, not empty: the block SHALL decrement Stack_Cnt; Return_Addr SHALL show the new top entry in the following cycle, or 0 if the stack becomes empty.
REQ-018 Push and Pop together, not empty: the block SHALL replace the top entry with Push_Addr and leave Stack_Cnt unchanged.
REQ-019 Push and Pop together, empty: the block SHALL treat the cycle as a push only and SHALL NOT set Stack_Unfl.
REQ-020 Push only, full: the block SHALL drop the push, leave the contents and Stack_Cnt unchanged, and set Stack_Ovfl.
REQ-021 Pop only, empty: the block SHALL ignore the pop, keep Return_Addr at 0, and set Stack_Unfl.
REQ-022 Stack_Ovfl and Stack_Unfl SHALL stay set until Err_Clr is sampled high.
REQ-023 If Err_Clr and a new error occur in the same cycle, the flag SHALL end that cycle set.
REQ-024 Return_Addr SHALL be 0 whenever Stack_Empty is high.
REQ-025 Stack_Full and Stack_Empty SHALL be decoded from the registered count and SHALL have no path from Push or Pop.
REQ-026 The latency from the Push or Pop edge to the updated outputs SHALL be exactly one clock.

Reset
REQ-027 On reset high, the block SHALL immediately force Stack_Cnt=0, Return_Addr=0, Stack_Empty=1, Stack_Full=0, Stack_Ovfl=0 and Stack_Unfl=0, regardless of the clock.
REQ-028 Entry storage SHALL NOT need a reset; on reset the stack SHALL be empty, so the old contents are unreachable.
REQ-029 A reset asserted in the middle of a push or pop SHALL win, and no partial update SHALL survive.

Structure
REQ-030 A shared package SHALL hold the ADDR_W/DEPTH defaults and a localparam for the count width.
REQ-031 The top of the stack SHALL be registered as a separate output register, not read through a combinational mux after the clock.
REQ-032 The entry storage SHALL be a single sub-module, rtn_addr_stack_regfile, with one write port and one read port.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 -> Return_Addr=0x33 and Stack_Cnt=3; then three pops -> Return_Addr shows 0x22, then 0x11, then 0x00, with Stack_Empty=1.
REQ-034 Push 8 addresses 0x40 to 0x47, then push 0x99 -> Stack_Full=1, Stack_Ovfl=1, Return_Addr=0x47, Stack_Cnt=8.
REQ-035 Pop on an empty stack -> Stack_Unfl=1 and Return_Addr=0x00; then pulse Err_Clr -> Stack_Unfl=0.
REQ-036 With 0xA0 on the stack, Push=Pop=1 with Push_Addr=0xB5 -> Return_Addr=0xB5, Stack_Cnt=1; on an empty stack the same stimulus -> Stack_Cnt=1 and Stack_Unfl=0.
REQ-037 Assert reset asynchronously between clock edges with 5 entries stored -> all outputs take their reset values before the next edge.
REQ-038 On a full stack, Push=Pop=1 with 0x5C -> top entry replaced, Stack_Cnt=8, Stack_Ovfl unchanged.

Source files
------------

// File: rtl/rtn_addr_stack_pkg.sv
// Shared defaults and operation encoding for the return-address stack.
package rtn_addr_stack_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

    // Effective stack operation after full/empty qualification.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } stack_op_e;

endpackage

// File: rtl/rtn_addr_stack_regfile.sv
// Return-address storage: one synchronous write port, one asynchronous read port, no reset.
module rtn_addr_stack_regfile #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [ADDR_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ADDR_W-1:0]        rd_data
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rtn_addr_stack.sv
// LIFO of call return addresses with registered top-of-stack, count and sticky error flags.
module rtn_addr_stack
    import rtn_addr_stack_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic [ADDR_W-1:0]          Push_Addr,
    input  logic                       Err_Clr,
    output logic [ADDR_W-1:0]          Return_Addr,
    output logic [$clog2(DEPTH):0]     Stack_Cnt,
    output logic                       Stack_Full,
    output logic                       Stack_Empty,
    output logic                       Stack_Ovfl,
    output logic                       Stack_Unfl
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] top_q;
    logic              ovfl_q;
    logic              unfl_q;
    logic              full;
    logic              empty;
    stack_op_e         op;
    logic              ovfl_set;
    logic              unfl_set;
    logic              we;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] rd_data;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    always_comb begin
        op       = OP_IDLE;
        ovfl_set = 1'b0;
        unfl_set = 1'b0;
        case ({Push, Pop})
            2'b10: begin
                if (full) ovfl_set = 1'b1;
                else      op       = OP_PUSH;
            end
            2'b01: begin
                if (empty) unfl_set = 1'b1;
                else       op       = OP_POP;
            end
            // Simultaneous call/return overwrites the top; on an empty stack it is a plain push.
            2'b11:   op = empty ? OP_PUSH : OP_REPL;
            default: op = OP_IDLE;
        endcase
    end

    assign we     = (op == OP_PUSH) || (op == OP_REPL);
    assign wr_idx = (op == OP_REPL) ? IDX_W'(cnt - CNT_W'(1)) : IDX_W'(cnt);
    // Entry just below the current top; becomes Return_Addr after a pop.
    assign rd_idx = IDX_W'(cnt - CNT_W'(2));

    rtn_addr_stack_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we      (we && !reset),
        .wr_idx  (wr_idx),
        .wr_data (Push_Addr),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            top_q  <= '0;
            ovfl_q <= 1'b0;
            unfl_q <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    cnt   <= cnt + CNT_W'(1);
                    top_q <= Push_Addr;
                end
                OP_POP: begin
                    cnt   <= cnt - CNT_W'(1);
                    top_q <= (cnt == CNT_W'(1)) ? '0 : rd_data;
                end
                OP_REPL: top_q <= Push_Addr;
                default: ;
            endcase
            ovfl_q <= (ovfl_q && !Err_Clr) || ovfl_set;
            unfl_q <= (unfl_q && !Err_Clr) || unfl_set;
        end
    end

    assign Return_Addr = top_q;
    assign Stack_Cnt   = cnt;
    assign Stack_Full  = full;
    assign Stack_Empty = empty;
    assign Stack_Ovfl  = ovfl_q;
    assign Stack_Unfl  = unfl_q;

endmodule

// File: tb/tb_rtn_addr_stack.sv
// Directed self-checking bench for rtn_addr_stack with default parameters.
module tb_rtn_addr_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic       Push;
    logic       Pop;
    logic [7:0] Push_Addr;
    logic       Err_Clr;
    logic [7:0] Return_Addr;
    logic [3:0] Stack_Cnt;
    logic       Stack_Full;
    logic       Stack_Empty;
    logic       Stack_Ovfl;
    logic       Stack_Unfl;

    int checks = 0;
    int errors = 0;

    rtn_addr_stack #(
        .ADDR_W (8),
        .DEPTH  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Push        (Push),
        .Pop         (Pop),
        .Push_Addr   (Push_Addr),
        .Err_Clr     (Err_Clr),
        .Return_Addr (Return_Addr),
        .Stack_Cnt   (Stack_Cnt),
        .Stack_Full  (Stack_Full),
        .Stack_Empty (Stack_Empty),
        .Stack_Ovfl  (Stack_Ovfl),
        .Stack_Unfl  (Stack_Unfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic p, input logic q, input logic [7:0] a, input logic c);
        Push      = p;
        Pop       = q;
        Push_Addr = a;
        Err_Clr   = c;
        @(posedge clk);
        #1;
        Push      = 1'b0;
        Pop       = 1'b0;
        Push_Addr = 8'h00;
        Err_Clr   = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] ra, input logic [3:0] cnt,
                             input logic fu, input logic em, input logic ov, input logic un);
        chk({tag, ".ret"},   32'(Return_Addr), 32'(ra));
        chk({tag, ".cnt"},   32'(Stack_Cnt),   32'(cnt));
        chk({tag, ".full"},  32'(Stack_Full),  32'(fu));
        chk({tag, ".empty"}, 32'(Stack_Empty), 32'(em));
        chk({tag, ".ovfl"},  32'(Stack_Ovfl),  32'(ov));
        chk({tag, ".unfl"},  32'(Stack_Unfl),  32'(un));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        Push      = 1'b0;
        Pop       = 1'b0;
        Push_Addr = 8'h00;
        Err_Clr   = 1'b0;
        #12;
        chk_state("reset", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic push/pop ordering
        cyc(1, 0, 8'h11, 0);
        chk("push11.ret", 32'(Return_Addr), 32'h11);
        cyc(1, 0, 8'h22, 0);
        cyc(1, 0, 8'h33, 0);
        chk_state("push33", 8'h33, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 8'h00, 0);
        chk_state("pop1", 8'h22, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 8'h00, 0);
        chk_state("pop2", 8'h11, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 8'h00, 0);
        chk_state("pop3", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Underflow, sticky until cleared
        cyc(0, 1, 8'h00, 0);
        chk_state("unfl", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(0, 0, 8'h00, 0);
        chk("unfl_sticky", 32'(Stack_Unfl), 32'd1);
        cyc(0, 0, 8'h00, 1);
        chk("unfl_clr", 32'(Stack_Unfl), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 8'(8'h40 + i), 0);
        end
        chk_state("fill", 8'h47, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1, 0, 8'h99, 0);
        chk_state("ovfl", 8'h47, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);

        // Replace on full stack keeps count and overflow flag
        cyc(1, 1, 8'h5C, 0);
        chk_state("repl_full", 8'h5C, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 1, 8'h00, 0);
        chk_state("pop_after_repl", 8'h46, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1, 0, 8'h77, 0);
        chk("refill.ret", 32'(Return_Addr), 32'h77);
        cyc(1, 0, 8'h88, 1);
        chk_state("clr_with_ovfl", 8'h77, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 8'h00, 1);
        chk("ovfl_clr", 32'(Stack_Ovfl), 32'd0);

        // Drain: contents below the top are 0x40..0x46
        cyc(0, 1, 8'h00, 0);
        chk("drain8.ret", 32'(Return_Addr), 32'h46);
        for (int n = 6; n >= 1; n--) begin
            cyc(0, 1, 8'h00, 0);
            chk("drain.ret", 32'(Return_Addr), 32'(8'h40 + n - 1));
            chk("drain.cnt", 32'(Stack_Cnt), 32'(n));
        end
        cyc(0, 1, 8'h00, 0);
        chk_state("drained", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Simultaneous push/pop, non-empty then empty
        cyc(1, 0, 8'hA0, 0);
        cyc(1, 1, 8'hB5, 0);
        chk_state("repl_one", 8'hB5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 8'h00, 0);
        chk("pop_repl_one.empty", 32'(Stack_Empty), 32'd1);
        cyc(1, 1, 8'hB5, 0);
        chk_state("pushpop_empty", 8'hB5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with 5 entries, push held active
        cyc(1, 0, 8'hC1, 0);
        cyc(1, 0, 8'hC2, 0);
        cyc(1, 0, 8'hC3, 0);
        cyc(1, 0, 8'hC4, 0);
        chk_state("five", 8'hC4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        chk("unfl_before_rst", 32'(Stack_Unfl), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'(8'hD0 + i), 0);
        end
        chk("five_again.cnt", 32'(Stack_Cnt), 32'd5);
        #2;
        Push      = 1'b1;
        Push_Addr = 8'hEE;
        reset     = 1'b1;
        #1;
        chk_state("async_rst", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_state("rst_held", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        Push  = 1'b0;
        reset = 1'b0;
        cyc(1, 0, 8'h12, 0);
        chk_state("post_rst_push", 8'h12, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 8'h00, 0);
        chk_state("post_rst_pop", 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
